// File: rtl/sif_bridge_pkg.sv
// ============================================================================
// sif_bridge_pkg : opcodes, ACK byte and FSM states for the SIF command bridge
// Rev 1.0
// ============================================================================
`default_nettype none

package sif_bridge_pkg;

    localparam logic [7:0] c_OPC_WR   = 8'hA5;
    localparam logic [7:0] c_OPC_RD   = 8'h5A;
    localparam logic [7:0] c_ACK_BYTE = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_TX    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sif_byte_ser.sv
// ============================================================================
// sif_byte_ser : loads up to 4 bytes and streams them MSB first over valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module sif_byte_ser (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_cnt,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        last_xfer
);

    logic [31:0] r_word;
    logic [2:0]  r_cnt;

    // Shifting zeros in keeps tx_data at 0 once the word has drained
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_word <= load_word;
            r_cnt  <= load_cnt;
        end else if (tx_valid && tx_ready) begin
            r_word <= {r_word[23:0], 8'h00};
            r_cnt  <= r_cnt - 3'd1;
        end
    end

    assign tx_valid  = (r_cnt != 3'd0);
    assign tx_data   = r_word[31:24];
    assign last_xfer = tx_valid && tx_ready && (r_cnt == 3'd1);

endmodule

`default_nettype wire

// File: rtl/sif_cmd_bridge.sv
// ============================================================================
// sif_cmd_bridge : byte-stream command decoder driving single-word SIF accesses
// Rev 1.0
// ============================================================================
`default_nettype none

module sif_cmd_bridge
    import sif_bridge_pkg::*;
#(
    parameter int SIF_AW      = 22,
    parameter int RD_LAT      = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [SIF_AW-1:0] sif_addr,
    output logic              sif_wen,
    output logic [31:0]       sif_wdata,
    output logic              sif_ren,
    input  logic [31:0]       sif_rdata,
    output logic              err_pulse
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] c_LAT_LAST = LW'(RD_LAT - 1);

    state_t             r_state;
    logic [1:0]         r_cnt;
    logic               r_is_wr;
    logic [SIF_AW-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic               r_wen;
    logic               r_ren;
    logic               r_err;
    logic [TW-1:0]      r_tmo;
    logic [LW-1:0]      r_lat;

    logic               w_ld;
    logic [31:0]        w_ld_word;
    logic [2:0]         w_ld_cnt;
    logic               w_tx_last;

    assign rx_ready  = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign sif_addr  = r_addr;
    assign sif_wdata = r_wdata;
    assign sif_wen   = r_wen;
    assign sif_ren   = r_ren;
    assign err_pulse = r_err;

    // Serializer is loaded on the edge that leaves WRITE or ends the read wait
    assign w_ld      = (r_state == ST_WRITE) || ((r_state == ST_RWAIT) && (r_lat == c_LAT_LAST));
    assign w_ld_word = (r_state == ST_WRITE) ? {c_ACK_BYTE, 24'h000000} : sif_rdata;
    assign w_ld_cnt  = (r_state == ST_WRITE) ? 3'd1 : 3'd4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wen   <= 1'b0;
            r_ren   <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= '0;
            r_lat   <= '0;
        end else begin
            r_wen <= 1'b0;
            r_ren <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_tmo <= '0;
                    if (rx_valid) begin
                        if ((rx_data == c_OPC_WR) || (rx_data == c_OPC_RD)) begin
                            r_is_wr <= (rx_data == c_OPC_WR);
                            r_state <= ST_ADDR;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (rx_valid) begin
                        r_tmo <= '0;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_state == ST_ADDR) begin
                            // Upper address bits beyond SIF_AW fall off the shift
                            r_addr <= {r_addr[SIF_AW-9:0], rx_data};
                            if (r_cnt == 2'd2) begin
                                r_cnt <= '0;
                                if (r_is_wr) begin
                                    r_state <= ST_WDATA;
                                end else begin
                                    r_state <= ST_READ;
                                    r_ren   <= 1'b1;
                                end
                            end
                        end else begin
                            r_wdata <= {r_wdata[23:0], rx_data};
                            if (r_cnt == 2'd3) begin
                                r_state <= ST_WRITE;
                                r_wen   <= 1'b1;
                            end
                        end
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_WRITE: r_state <= ST_TX;
                ST_READ: begin
                    r_lat   <= '0;
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (r_lat == c_LAT_LAST) begin
                        r_state <= ST_TX;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                ST_TX: begin
                    if (w_tx_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sif_byte_ser u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load      (w_ld),
        .load_word (w_ld_word),
        .load_cnt  (w_ld_cnt),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .last_xfer (w_tx_last)
    );

endmodule

`default_nettype wire
